// File: rtl/cache_access_arbiter.sv
// Two-port front end for a direct-mapped data cache. Each access is looked
// up, refilled from main memory on a miss, and answered with one word.
//
// Request handshake: a requester raises reqN_valid with a stable reqN_addr
// and holds both until reqN_done pulses for one cycle with reqN_data valid.
// It drops reqN_valid in the cycle after done. Valid is sampled only in
// IDLE, so a request withdrawn before it is granted is never seen.
// Memory handshake: mem_read is held until mem_ready pulses for one cycle
// with the refill line on mem_data. There is no bound on that wait.
module cache_access_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    input  logic [ADDR_W-1:0]            req0_addr,
    output logic                         req0_done,
    output logic [WORD_W-1:0]            req0_data,
    input  logic                         req1_valid,
    input  logic [ADDR_W-1:0]            req1_addr,
    output logic                         req1_done,
    output logic [WORD_W-1:0]            req1_data,
    output logic                         cache_read,
    output logic [ADDR_W-1:0]            cache_address,
    input  logic                         cache_hit,
    input  logic [WORD_W-1:0]            cache_data,
    output logic                         cache_write,
    output logic [LINE_WORDS*WORD_W-1:0] cache_fill_data,
    output logic                         mem_read,
    output logic [ADDR_W-1:0]            mem_address,
    input  logic                         mem_ready,
    input  logic [LINE_WORDS*WORD_W-1:0] mem_data,
    input  logic                         clr_stats,
    output logic                         busy,
    output logic [CNT_W-1:0]             hit_count,
    output logic [CNT_W-1:0]             access_count,
    output logic [2:0]                   dbgState
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int LINE_W = LINE_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MEM_REQ = 3'd2,
        FILL    = 3'd3,
        RESPOND = 3'd4
    } arbStateT;

    arbStateT           state;
    arbStateT           nextState;
    logic               grantQ;      // 0: port 0 owns the access, 1: port 1
    logic               lastGrantQ;
    logic               grantPick;
    logic               anyValid;
    logic [ADDR_W-1:0]  addrQ;
    logic [LINE_W-1:0]  lineQ;
    logic [WORD_W-1:0]  req0DataQ;
    logic [WORD_W-1:0]  req1DataQ;
    logic [WORD_W-1:0]  fillWord;
    logic [WORD_W-1:0]  respWord;
    logic               respLoad;
    logic [CNT_W-1:0]   hitCntQ;
    logic [CNT_W-1:0]   accCntQ;

    // Round-robin choice: on a tie the port that did not win last time goes.
    assign anyValid  = req0_valid | req1_valid;
    assign grantPick = (req0_valid & req1_valid) ? ~lastGrantQ : req1_valid;

    // Word the requester asked for, picked out of the refill line by offset.
    assign fillWord = lineQ[WORD_W*int'(addrQ[OFF_W-1:0]) +: WORD_W];

    // Response data is loaded on a hit in LOOKUP or from the line in FILL.
    assign respLoad = ((state == LOOKUP) && cache_hit) || (state == FILL);
    assign respWord = (state == FILL) ? fillWord : cache_data;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (anyValid) nextState = LOOKUP;
            LOOKUP:  nextState = cache_hit ? RESPOND : MEM_REQ;
            MEM_REQ: if (mem_ready) nextState = FILL;
            FILL:    nextState = RESPOND;
            RESPOND: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Grant, address and refill line capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grantQ     <= 1'b0;
            lastGrantQ <= 1'b1;
            addrQ      <= '0;
            lineQ      <= '0;
        end else begin
            if (state == IDLE && anyValid) begin
                grantQ     <= grantPick;
                lastGrantQ <= grantPick;
                addrQ      <= grantPick ? req1_addr : req0_addr;
            end
            if (state == MEM_REQ && mem_ready) lineQ <= mem_data;
        end
    end

    // Per-port read data; the port not being served keeps its old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req0DataQ <= '0;
            req1DataQ <= '0;
        end else if (respLoad) begin
            if (grantQ) req1DataQ <= respWord;
            else        req0DataQ <= respWord;
        end
    end

    // Saturating statistics; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitCntQ <= '0;
            accCntQ <= '0;
        end else if (clr_stats) begin
            hitCntQ <= '0;
            accCntQ <= '0;
        end else if (state == LOOKUP) begin
            if (accCntQ != CNT_MAX) accCntQ <= accCntQ + 1'b1;
            if (cache_hit && hitCntQ != CNT_MAX) hitCntQ <= hitCntQ + 1'b1;
        end
    end

    // Strobes are decoded straight from the state so reset drops them at once.
    assign cache_read      = (state == LOOKUP);
    assign cache_write     = (state == FILL);
    assign mem_read        = (state == MEM_REQ);
    assign busy            = (state != IDLE);
    assign req0_done       = (state == RESPOND) && !grantQ;
    assign req1_done       = (state == RESPOND) && grantQ;
    assign cache_address   = addrQ;
    assign mem_address     = {addrQ[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign cache_fill_data = lineQ;
    assign req0_data       = req0DataQ;
    assign req1_data       = req1DataQ;
    assign hit_count       = hitCntQ;
    assign access_count    = accCntQ;
    assign dbgState        = state;

endmodule
